fp_add_arbiter: RTL and testbench

- Shares one fixed-latency pipelined FP32 adder among N_REQ requesters.
- Round-robin issue of at most one operand pair per cycle into the adder.
- Tags each issue with its requester id and routes each result back on a one-hot response bus.
- Provides a halt/drain handshake so upstream control can quiesce the adder, e.g. before reconfiguration or test.

---
 rtl/fp_add_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_fp_add_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter
//   Shares one fixed-latency pipelined FP32 adder among N_REQ requesters.
//   At most one operand pair is issued per cycle, in round-robin order. Each
//   issue carries its requester id down a tag pipe that runs alongside the
//   adder, so each result is returned to the requester that owns it.
//   A halt/drain handshake lets upstream control quiesce the adder.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   req_valid/ready   per-requester handshake; ready is combinational
//   req_a, req_b      packed operands, requester i on bits [32i+31:32i]
//   add_a, add_b      operands to the shared adder (zero when nothing issues)
//   add_result        adder output, ADDER_LAT cycles after add_a/add_b
//   rsp_valid         registered one-hot response strobe (single-cycle pulse)
//   rsp_data          registered result; holds its value between responses
//   halt_req          stop issuing and drain the adder
//   halted            registered; adder empty and issue blocked
//   busy              something is in the adder or a response is pending
module fp_add_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ADDER_LAT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  input  logic [31:0]          add_result,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [31:0]          rsp_data,
  input  logic                 halt_req,
  output logic                 halted,
  output logic                 busy
);

  localparam int ID_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  localparam int TAIL = ADDER_LAT - 1;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [ID_W-1:0]      rr;
  logic [ADDER_LAT-1:0] pipe_vld;
  logic [ID_W-1:0]      pipe_id [ADDER_LAT];

  logic                 issue_en;
  logic                 grant_found;
  logic [ID_W-1:0]      grant_id;
  logic [N_REQ-1:0]     grant_oh;
  logic                 handshake;
  logic [N_REQ-1:0]     tail_oh;
  logic                 drained;

  // ---------------------------------------------------------------------
  // Round-robin search: first the requesters above the last grant, then
  // wrap around to those at or below it. The last grant is therefore the
  // lowest priority on the following cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned and no latch is inferred.
    grant_found = 1'b0;
    grant_id    = '0;
    grant_oh    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_found && req_valid[i] && (i > int'(rr))) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(i);
        grant_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_found && req_valid[i] && (i <= int'(rr))) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(i);
        grant_oh[i] = 1'b1;
      end
    end
  end

  assign req_ready = issue_en ? grant_oh : '0;
  assign handshake = issue_en & grant_found;

  // Operand mux; idle cycles feed zeros so the adder input is deterministic.
  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (issue_en && grant_oh[i]) begin
        add_a = req_a[32*i +: 32];
        add_b = req_b[32*i +: 32];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM. Issue is blocked combinationally in the very cycle
  // halt_req is first seen, before the state register has moved.
  // ---------------------------------------------------------------------
  assign drained = ~|pipe_vld && ~|rsp_valid;
  assign busy    = ~drained;

  always_comb begin
    state_next = state;
    issue_en   = 1'b0;
    case (state)
      S_RUN: begin
        issue_en = ~halt_req;
        if (halt_req) state_next = S_DRAIN;
      end
      // A halt_req drop here is ignored: the drain always completes.
      S_DRAIN: begin
        if (drained) state_next = S_HALTED;
      end
      S_HALTED: begin
        if (!halt_req) state_next = S_RUN;
      end
      default: state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    if (reset) begin
      state  <= S_RUN;
      halted <= 1'b0;
      rr     <= ID_W'(N_REQ - 1);
    end else begin
      state  <= state_next;
      halted <= (state_next == S_HALTED);
      if (handshake) rr <= grant_id;
    end
  end

  // ---------------------------------------------------------------------
  // Tag pipe: one {valid, id} slot per adder stage. The tail lines up with
  // add_result. Clearing the valid bits on reset discards whatever the
  // adder still holds.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= handshake;
      for (int k = 1; k < ADDER_LAT; k++) pipe_vld[k] <= pipe_vld[k-1];
    end
  end

  // NOTE: the id slots are not reset; they are only ever read when the
  // matching valid bit is set, and that bit is reset.
  always_ff @(posedge clk) begin
    pipe_id[0] <= grant_id;
    for (int k = 1; k < ADDER_LAT; k++) pipe_id[k] <= pipe_id[k-1];
  end

  always_comb begin
    tail_oh = '0;
    for (int i = 0; i < N_REQ; i++) tail_oh[i] = (pipe_id[TAIL] == ID_W'(i));
  end

  // Response register: one-cycle pulse, data held between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else if (pipe_vld[TAIL]) begin
      rsp_valid <= tail_oh;
      rsp_data  <= add_result;
    end else begin
      rsp_valid <= '0;
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter
//   Self-checking bench for fp_add_arbiter (N_REQ=4, ADDER_LAT=4). The adder
//   is a 4-stage integer-sum stub, so every routed result is exact.
//   A reference model (round-robin by modular search, a queue of in-flight
//   operations with due cycles, and a three-mode halt controller) is checked
//   against the DUT on every cycle; directed phases add literal expectations.
module tb_fp_add_arbiter;

  localparam int N   = 4;
  localparam int LAT = 4;
  localparam int IW  = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [31:0]      ra [N];
  logic [31:0]      rb [N];
  logic [32*N-1:0]  req_a;
  logic [32*N-1:0]  req_b;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      add_result;
  logic [N-1:0]     rsp_valid;
  logic [31:0]      rsp_data;
  logic             halt_req;
  logic             halted;
  logic             busy;
  logic [31:0]      adder_pipe [LAT];
  logic [N-1:0]     hs_last;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = ra[i];
      req_b[32*i +: 32] = rb[i];
    end
  end

  // Adder stub: result of operands driven in cycle t appears in cycle t+4.
  always @(posedge clk) begin
    adder_pipe[0] <= add_a + add_b;
    for (int k = 1; k < LAT; k++) adder_pipe[k] <= adder_pipe[k-1];
  end
  assign add_result = adder_pipe[LAT-1];

  fp_add_arbiter #(.N_REQ(N), .ADDER_LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .halt_req   (halt_req),
    .halted     (halted),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  typedef enum int {M_RUN, M_DRAIN, M_HALTED} mode_e;
  typedef struct {
    int          due;
    int          id;
    logic [31:0] sum;
  } op_t;

  op_t         q[$];
  int          m_rr;
  mode_e       m_mode;
  logic [31:0] m_data;
  int          cyc = 0;

  initial begin : compare
    logic [N-1:0]  e_ready;
    logic [N-1:0]  e_rsp;
    logic [31:0]   e_a;
    logic [31:0]   e_b;
    logic          e_busy;
    logic [IW-1:0] gi;
    int            g;
    int            rv;
    int            j;
    op_t           op;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        m_rr   = N - 1;
        m_mode = M_RUN;
        m_data = '0;
      end else begin
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        e_rsp = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
          e_rsp  = N'(1 << q[0].id);
          m_data = q[0].sum;
        end
        e_busy = (q.size() > 0);

        g  = -1;
        rv = int'(req_valid);
        if (m_mode == M_RUN && !halt_req) begin
          for (int k = 1; k <= N; k++) begin
            j = (m_rr + k) % N;
            if (g < 0 && ((rv >> j) & 1) == 1) g = j;
          end
        end
        e_ready = '0;
        e_a     = '0;
        e_b     = '0;
        if (g >= 0) begin
          gi      = IW'(g);
          e_ready = N'(1 << g);
          e_a     = ra[gi];
          e_b     = rb[gi];
        end

        check("ready",     32'(req_ready), 32'(e_ready));
        check("add_a",     add_a,          e_a);
        check("add_b",     add_b,          e_b);
        check("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
        check("rsp_data",  rsp_data,       m_data);
        check("halted",    32'(halted),    32'(m_mode == M_HALTED));
        check("busy",      32'(busy),      32'(e_busy));

        if (g >= 0) begin
          op.due = cyc + LAT + 1;
          op.id  = g;
          op.sum = e_a + e_b;
          q.push_back(op);
          m_rr = g;
        end
        case (m_mode)
          M_RUN:    if (halt_req) m_mode = M_DRAIN;
          M_DRAIN:  if (!e_busy)  m_mode = M_HALTED;
          default:  if (!halt_req) m_mode = M_RUN;
        endcase
      end
      cyc++;
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    step();
    reset     = 1'b1;
    req_valid = '0;
    halt_req  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < N; i++) begin
      ra[i] = $urandom;
      rb[i] = $urandom;
    end
  endtask

  // Random traffic that respects the hold rule: a requester that is valid
  // and was not accepted keeps its request unchanged.
  task automatic rand_step(input int p, input logic h);
    step();
    for (int i = 0; i < N; i++) begin
      if (!(req_valid[i] && !hs_last[i])) begin
        req_valid[i] = ($urandom_range(99) < p);
        ra[i]        = $urandom;
        rb[i]        = $urandom;
      end
    end
    halt_req = h;
    @(negedge clk);
    hs_last = req_valid & req_ready;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int   n_halt;
    logic h;
    reset     = 1'b1;
    req_valid = '0;
    halt_req  = 1'b0;
    hs_last   = '1;
    for (int i = 0; i < N; i++) begin
      ra[i] = '0;
      rb[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_data",  rsp_data,       32'h0);
    check("reset_halted",    32'(halted),    32'h0);
    check("reset_busy",      32'(busy),      32'h0);

    // 1: single request from requester 1
    step();
    ra[1]     = 32'h10;
    rb[1]     = 32'h05;
    req_valid = 4'b0010;
    @(negedge clk);
    check("t1_ready", 32'(req_ready), 32'h2);
    check("t1_busy0", 32'(busy),      32'h0);
    for (int c = 1; c <= 6; c++) begin
      step();
      req_valid = '0;
      @(negedge clk);
      check("t1_busy",      32'(busy),      32'(c <= 5));
      check("t1_rsp_valid", 32'(rsp_valid), (c == 5) ? 32'h2 : 32'h0);
      if (c == 5) check("t1_rsp_data", rsp_data, 32'h15);
    end

    // 2: all four valid continuously for 8 cycles -> strict rotation
    apply_reset();
    for (int i = 0; i < N; i++) begin
      ra[i] = 32'(i);
      rb[i] = 32'h100;
    end
    for (int c = 0; c <= 12; c++) begin
      step();
      req_valid = (c < 8) ? 4'hF : 4'h0;
      @(negedge clk);
      if (c < 8) check("t2_grant", 32'(req_ready), 32'(1 << (c % 4)));
      if (c >= 5) begin
        check("t2_rsp_valid", 32'(rsp_valid), 32'(1 << ((c - 5) % 4)));
        check("t2_rsp_data",  rsp_data,       32'h100 + 32'((c - 5) % 4));
      end
    end

    // 3: req0 and req2 contend after a lone req2 issue -> alternate
    apply_reset();
    randomize_ops();
    step();
    req_valid = 4'b0100;
    @(negedge clk);
    check("t3_first", 32'(req_ready), 32'h4);
    for (int c = 1; c <= 16; c++) begin
      step();
      req_valid = 4'b0101;
      @(negedge clk);
      check("t3_alt", 32'(req_ready), (c % 2 == 1) ? 32'h1 : 32'h4);
    end
    step();
    req_valid = '0;
    repeat (7) step();

    // 4: halt raised at cycle 3, dropped at cycle 12
    apply_reset();
    randomize_ops();
    for (int c = 0; c <= 13; c++) begin
      step();
      req_valid = 4'hF;
      halt_req  = (c >= 3 && c < 12);
      @(negedge clk);
      if (c < 3)               check("t4_grant",  32'(req_ready), 32'(1 << c));
      if (c >= 3 && c <= 12)   check("t4_blocked", 32'(req_ready), 32'h0);
      if (c == 13)             check("t4_resume", 32'(req_ready), 32'h8);
      check("t4_halted", 32'(halted), 32'(c >= 9 && c <= 12));
      if (c >= 5 && c <= 7)    check("t4_rsp", 32'(rsp_valid), 32'(1 << (c - 5)));
      if (c == 8)              check("t4_rsp_done", 32'(rsp_valid), 32'h0);
    end
    step();
    req_valid = '0;
    halt_req  = 1'b0;
    repeat (7) step();

    // 5: asynchronous reset mid-cycle with operations in flight
    apply_reset();
    randomize_ops();
    for (int c = 0; c <= 5; c++) begin
      step();
      req_valid = 4'hF;
    end
    #2;
    reset = 1'b1;
    #1;
    check("t5_rsp_valid", 32'(rsp_valid), 32'h0);
    check("t5_rsp_data",  rsp_data,       32'h0);
    check("t5_halted",    32'(halted),    32'h0);
    check("t5_busy",      32'(busy),      32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("t5_first_grant", 32'(req_ready), 32'h1);
    for (int c = 1; c <= 4; c++) begin
      step();
      @(negedge clk);
      check("t5_no_spurious", 32'(rsp_valid), 32'h0);
    end
    step();
    req_valid = '0;
    repeat (8) step();

    // 6: one-cycle halt pulse during traffic -> exactly one halted cycle
    hs_last = '1;
    n_halt  = 0;
    for (int c = 0; c < 40; c++) begin
      rand_step(60, c == 10);
      if (halted) n_halt++;
    end
    check("t6_halted_cycles", 32'(n_halt), 32'h1);

    // Random traffic with occasional halt toggles
    for (int c = 0; c < 500; c++) begin
      h = halt_req;
      if ($urandom_range(99) < 4) h = ~h;
      rand_step(int'($urandom_range(20, 90)), h);
    end

    step();
    req_valid = '0;
    halt_req  = 1'b0;
    repeat (12) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
